// File: rtl/sm4_pkg.sv
// Shared SM4 constants and helpers: FK, CK generation, S-box table, rotate.
// Used by the key-expansion engine and the cipher datapath.
package sm4_pkg;

  localparam int ROUNDS = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} ke_state_t;

  localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // CK_i byte j (j=0 is the MSB) is ((4i+j)*7) mod 256.
  function automatic logic [31:0] ck_word(input logic [4:0] i);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = 8'(({1'b0, i, 2'b00} + 8'(j)) * 8'd7);
    end
    return w;
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_sbox.sv
// Byte-wide SM4 S-box lookup, purely combinational; shared with the cipher datapath.
module sm4_sbox
  import sm4_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX[a];
endmodule

// File: rtl/sm4_keyexp.sv
// SM4 key expansion: one round key per clock into a 32-word key file with an indexed read port.
// Optional SM4_KEYEXP_ZEROIZE_EN adds a zeroize input that wipes all key material.
module sm4_keyexp #(
  parameter int ROUNDS = sm4_pkg::ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] mk,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [4:0]   rd_idx,
  input  logic         rd_rev,
  output logic [31:0]  rk
`ifdef SM4_KEYEXP_ZEROIZE_EN
  ,
  input  logic         zeroize
`endif
);
  import sm4_pkg::*;

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  ke_state_t   state_reg;
  logic [31:0] win_reg [4];
  logic [4:0]  cnt_reg;
  logic        busy_reg, done_reg, kv_reg;
  logic [31:0] rk_reg;
  logic [ROUNDS*32-1:0] kf_flat;
  logic        zero;
  logic [31:0] mix, tau, k_next;
  logic [4:0]  rd_addr;
  genvar gi;

`ifdef SM4_KEYEXP_ZEROIZE_EN
  assign zero = zeroize;
`else
  assign zero = 1'b0;
`endif

  // Round function: K_{i+4} = K_i ^ L'(tau(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i)).
  assign mix = win_reg[1] ^ win_reg[2] ^ win_reg[3] ^ ck_word(cnt_reg);
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sm4_sbox u_sbox (.a(mix[8*gi +: 8]), .y(tau[8*gi +: 8]));
    end
  endgenerate
  assign k_next = win_reg[0] ^ tau ^ rotl32(tau, 13) ^ rotl32(tau, 23);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      kv_reg    <= 1'b0;
      for (int i = 0; i < 4; i++) win_reg[i] <= '0;
    end else if (zero) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      kv_reg    <= 1'b0;
      for (int i = 0; i < 4; i++) win_reg[i] <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          for (int i = 0; i < 4; i++) win_reg[i] <= mk[127-32*i -: 32] ^ FK[i];
          cnt_reg   <= '0;
          kv_reg    <= 1'b0;
          busy_reg  <= 1'b1;
          state_reg <= RUN;
        end
        RUN: begin
          win_reg[0] <= win_reg[1];
          win_reg[1] <= win_reg[2];
          win_reg[2] <= win_reg[3];
          win_reg[3] <= k_next;
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          kv_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Key file: one register per round key, written when the counter selects it.
  generate
    for (gi = 0; gi < ROUNDS; gi++) begin : g_kf
      logic [31:0] word_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          word_reg <= '0;
        else if (zero)
          word_reg <= '0;
        else if (state_reg == RUN && cnt_reg == 5'(gi))
          word_reg <= k_next;
      end
      assign kf_flat[32*gi +: 32] = word_reg;
    end
  endgenerate

  assign rd_addr = rd_rev ? LAST - rd_idx : rd_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rk_reg <= '0;
    else if (zero)
      rk_reg <= '0;
    else
      rk_reg <= kf_flat[32*rd_addr +: 32];
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign key_valid = kv_reg;
  assign rk        = rk_reg;

endmodule

// File: tb/tb_sm4_keyexp.sv
// Directed bench for sm4_keyexp: whole-schedule reference model plus per-cycle output compare.
module tb_sm4_keyexp;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         rd_rev = 1'b0;
  logic [4:0]   rd_idx = '0;
  logic [127:0] mk = '0;
  logic         busy, done, key_valid;
  logic [31:0]  rk;
`ifdef SM4_KEYEXP_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  localparam logic [127:0] STD_MK = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ALT_MK = 128'hffffffff00000000deadbeefcafef00d;

  always #5 clk = ~clk;

  sm4_keyexp dut (
    .clk(clk), .rst(rst), .mk(mk), .start(start),
    .busy(busy), .done(done), .key_valid(key_valid),
    .rd_idx(rd_idx), .rd_rev(rd_rev), .rk(rk)
`ifdef SM4_KEYEXP_ZEROIZE_EN
    , .zeroize(zeroize)
`endif
  );

  logic [31:0] fk [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
  logic [7:0] sb [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [31:0] tprime(input logic [31:0] x);
    logic [31:0] b;
    b = {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Whole schedule straight from the recurrence over K0..K35.
  function automatic void expand(input logic [127:0] key, output logic [31:0] o [32]);
    logic [31:0] k [36];
    logic [31:0] ck;
    for (int i = 0; i < 4; i++) k[i] = key[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4*i + j) * 7) % 256)};
      k[i+4] = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      o[i] = k[i+4];
    end
  endfunction

  // Reference state: cycles since accepted start, expected outputs, expected key file.
  int          m_t = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_kv = 1'b0;
  logic [31:0] m_rk = '0;
  logic [31:0] m_kf [32];
  logic [31:0] m_sched [32];

  initial begin
    for (int i = 0; i < 32; i++) m_kf[i] = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_t = 0; m_busy = 1'b0; m_done = 1'b0; m_kv = 1'b0; m_rk = '0;
        for (int i = 0; i < 32; i++) m_kf[i] = '0;
      end
`ifdef SM4_KEYEXP_ZEROIZE_EN
      else if (zeroize) begin
        m_t = 0; m_busy = 1'b0; m_done = 1'b0; m_kv = 1'b0; m_rk = '0;
        for (int i = 0; i < 32; i++) m_kf[i] = '0;
      end
`endif
      else begin
        m_rk = m_kf[rd_rev ? 31 - int'(rd_idx) : int'(rd_idx)];
        m_done = 1'b0;
        if (m_t == 0) begin
          if (start) begin
            expand(mk, m_sched);
            m_t = 1;
            m_kv = 1'b0;
          end
        end else begin
          if (m_t <= 32) m_kf[m_t-1] = m_sched[m_t-1];
          if (m_t == 33) begin
            m_t = 0; m_done = 1'b1; m_kv = 1'b1;
          end else begin
            m_t++;
          end
        end
        m_busy = (m_t != 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check1("cmp_busy", busy, m_busy);
      check1("cmp_done", done, m_done);
      check1("cmp_key_valid", key_valid, m_kv);
      check("cmp_rk", rk, m_rk);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic rev, input int idx, input logic [31:0] exp);
    rd_rev = rev;
    rd_idx = 5'(idx);
    tick();
    check($sformatf("read rev=%0d idx=%0d", rev, idx), rk, exp);
    $display("[TB] read rev=%0d idx=%0d rk=%h", rev, idx, rk);
  endtask

  task automatic sweep();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) begin
        rd_rev = r[0];
        rd_idx = 5'(i);
        tick();
      end
    end
  endtask

  // Pulse start with key; hold key_after from the next cycle; optionally inject a second start.
  task automatic run(input logic [127:0] key, input logic [127:0] key_after, input int inject);
    int n;
    mk = key;
    start = 1'b1;
    tick();
    start = 1'b0;
    mk = key_after;
    n = 1;
    check1("busy_after_start", busy, 1'b1);
    while (!done && n < 100) begin
      if (n == inject) begin start = 1'b1; mk = ALT_MK; end
      tick();
      n++;
      if (n == inject + 1) begin start = 1'b0; mk = key_after; end
    end
    check("done_latency", 32'(n), 32'd34);
    check1("key_valid_at_done", key_valid, 1'b1);
    $display("[TB] run mk=%h done after %0d cycles", key, n);
  endtask

  initial begin
    logic [31:0] ref_keys [32];
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_key_valid", key_valid, 1'b0);
    check("reset_rk", rk, 32'h0);
    rst = 1'b0;
    tick();

    expand(STD_MK, ref_keys);
    check("model_rk0", ref_keys[0], 32'hf12186f9);
    check("model_rk1", ref_keys[1], 32'h41662b61);
    check("model_rk31", ref_keys[31], 32'h9124a012);

    run(STD_MK, STD_MK, 0);
    rd(1'b0, 0, 32'hf12186f9);
    rd(1'b0, 1, 32'h41662b61);
    rd(1'b0, 31, 32'h9124a012);
    rd(1'b1, 0, 32'h9124a012);
    rd(1'b1, 31, 32'hf12186f9);
    sweep();

    run(ALT_MK, ALT_MK, 0);
    run(STD_MK, 128'h0, 0);
    rd(1'b0, 0, 32'hf12186f9);
    rd(1'b1, 0, 32'h9124a012);

    run(STD_MK, STD_MK, 10);
    rd(1'b0, 1, 32'h41662b61);
    check1("no_restart_busy", busy, 1'b0);

    run(ALT_MK, ALT_MK, 0);
    run(STD_MK, STD_MK, 0);
    sweep();

    mk = ALT_MK;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    #1;
    check1("rst_mid_busy", busy, 1'b0);
    check1("rst_mid_done", done, 1'b0);
    check1("rst_mid_key_valid", key_valid, 1'b0);
    check("rst_mid_rk", rk, 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check1("rst_kv_stays_low", key_valid, 1'b0);
    rd(1'b0, 0, 32'h0);
    rd(1'b1, 0, 32'h0);
    run(STD_MK, STD_MK, 0);
    rd(1'b1, 31, 32'hf12186f9);

`ifdef SM4_KEYEXP_ZEROIZE_EN
    zeroize = 1'b1;
    start = 1'b1;
    mk = ALT_MK;
    tick();
    zeroize = 1'b0;
    start = 1'b0;
    check1("zeroize_key_valid", key_valid, 1'b0);
    check1("zeroize_busy", busy, 1'b0);
    check("zeroize_rk", rk, 32'h0);
    for (int i = 0; i < 32; i++) rd(1'b0, i, 32'h0);
    check1("zeroize_no_run", busy, 1'b0);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
